// File: rtl/mem_pkg.sv
// Shared types and constants for the memory request controller.
//   mem_req_t       : one queued request {we, addr, wdata}
//   state_t         : controller FSM states (ST_ERR exists only when the
//                     MEM_REQ_TIMEOUT_EN build macro is defined)
//   DATA_W, ADDR_W  : data / address widths
//   CYCLE_TO_FINISH : nominal memory latency, in strobe cycles
package mem_pkg;

    localparam int DATA_W          = 128;
    localparam int ADDR_W          = 32;
    localparam int CYCLE_TO_FINISH = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

`ifdef MEM_REQ_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/mem_req_fifo.sv
// Request queue for mem_req_ctrl.
// The queue holds DEPTH entries of mem_req_t. Its pointers are one bit wider
// than the index, which lets a full queue be told apart from an empty one.
// The storage array has no reset, so it can map onto RAM primitives.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the queue)
//   push, din   : write one entry (the caller guarantees !full)
//   pop, dout   : dout always shows the head; pop advances it (the caller
//                 guarantees !empty)
//   full, empty : occupancy flags
module mem_req_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  mem_req_t din,
    input  logic     pop,
    output mem_req_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    mem_req_t    mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    assign dout  = mem[rd_ptr_reg[AW-1:0]];
    // The pointers wrap modulo 2*DEPTH, so the MSBs differ only after the
    // writer has lapped the reader.
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory request controller. Core requests are queued, then issued to
// memory one at a time through a registered issue stage. A one-cycle
// response is returned for each rdy_mem handshake, in request order.
// Build macro: MEM_REQ_TIMEOUT_EN adds a watchdog. If no rdy_mem arrives
// within TIMEOUT_CYCLES busy cycles, the controller enters ST_ERR, sets the
// sticky err_timeout flag, and stays there until reset.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   req_valid/ready/we/addr/wdata       : core request handshake
//   resp_valid/we/rdata                 : one-cycle response (no backpressure)
//   we_mem/re_mem/addr_mem/data_mem_out : memory strobes, address, store data
//   rdy_mem, data_mem_in                : memory completion and load data
//   err_timeout                         : sticky watchdog flag (0 without macro)
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_we,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              we_mem,
    output logic              re_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] data_mem_out,
    input  logic              rdy_mem,
    input  logic [DATA_W-1:0] data_mem_in,
    output logic              err_timeout
);

    state_t   state_reg;
    state_t   state_next;
    logic     alive_reg;
    logic     fifo_full;
    logic     fifo_empty;
    logic     push;
    logic     pop;
    logic     finish;
    logic     drop;
    mem_req_t fifo_din;
    mem_req_t fifo_dout;

    // alive_reg keeps req_ready low while reset is asserted. It goes high on
    // the first clock edge after reset is released.
`ifdef MEM_REQ_TIMEOUT_EN
    assign req_ready = alive_reg && !fifo_full && (state_reg != ST_ERR);
`else
    assign req_ready = alive_reg && !fifo_full;
`endif
    assign push     = req_valid && req_ready;
    assign fifo_din = '{we: req_we, addr: req_addr, wdata: req_wdata};

    mem_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            err_reg;
    logic            wd_expire;

    // Expires on the edge where the count would reach TIMEOUT_CYCLES.
    assign wd_expire = (state_reg == ST_BUSY) && !rdy_mem &&
                       (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (pop || rdy_mem) begin
                wd_cnt_reg <= '0;
            end else if (state_reg == ST_BUSY) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
            if (wd_expire) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err_timeout = err_reg;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // pop   : move the FIFO head into the issue register
    // finish: the memory completed the current request on this edge
    // drop  : deassert both strobes
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        finish     = 1'b0;
        drop       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rdy_mem) begin
                    finish = 1'b1;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        drop       = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
`ifdef MEM_REQ_TIMEOUT_EN
                else if (wd_expire) begin
                    drop       = 1'b1;
                    state_next = ST_ERR;
                end
`endif
            end
            default: begin
                state_next = state_reg;
            end
        endcase
    end

    // Issue register and response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_reg    <= 1'b0;
            we_mem       <= 1'b0;
            re_mem       <= 1'b0;
            addr_mem     <= '0;
            data_mem_out <= '0;
            resp_valid   <= 1'b0;
            resp_we      <= 1'b0;
            resp_rdata   <= '0;
        end else begin
            alive_reg  <= 1'b1;
            resp_valid <= finish;
            if (finish) begin
                resp_we    <= we_mem;
                resp_rdata <= we_mem ? '0 : data_mem_in;
            end
            if (pop) begin
                we_mem       <= fifo_dout.we;
                re_mem       <= !fifo_dout.we;
                addr_mem     <= fifo_dout.addr;
                data_mem_out <= fifo_dout.wdata;
            end else if (drop) begin
                we_mem <= 1'b0;
                re_mem <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed testbench for mem_req_ctrl. A memory responder raises rdy_mem
// CYCLE_TO_FINISH strobe cycles after each issue and checks the issued
// request. A response monitor checks each resp_valid against the request
// queue.
module tb_mem_req_ctrl;
    import mem_pkg::*;

    localparam int FIFO_DEPTH     = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int LAT            = CYCLE_TO_FINISH;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_we = 1'b0;
    logic [ADDR_W-1:0]  req_addr = '0;
    logic [DATA_W-1:0]  req_wdata = '0;
    logic               resp_valid;
    logic               resp_we;
    logic [DATA_W-1:0]  resp_rdata;
    logic               we_mem;
    logic               re_mem;
    logic [ADDR_W-1:0]  addr_mem;
    logic [DATA_W-1:0]  data_mem_out;
    logic               rdy_mem;
    logic [DATA_W-1:0]  data_mem_in = '0;
    logic               err_timeout;

    logic     mem_rdy_drv = 1'b0;
    logic     force_rdy = 1'b0;
    bit       mem_en = 1'b1;
    int       mem_cnt = 0;
    int       n_checks = 0;
    int       n_fail = 0;
    int       n_resp = 0;
    mem_req_t exp_q[$];
    mem_req_t iss_q[$];

    assign rdy_mem = mem_rdy_drv | force_rdy;

    always #5 clk = ~clk;

    mem_req_ctrl #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_we      (resp_we),
        .resp_rdata   (resp_rdata),
        .we_mem       (we_mem),
        .re_mem       (re_mem),
        .addr_mem     (addr_mem),
        .data_mem_out (data_mem_out),
        .rdy_mem      (rdy_mem),
        .data_mem_in  (data_mem_in),
        .err_timeout  (err_timeout)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rdata_fn(input logic [31:0] a);
        if (a == 32'h0001_0008) return 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
    endfunction

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    // Presents one request and holds it until it is accepted. waits counts
    // the sampled cycles in which req_ready was low.
    task automatic send(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                        output int waits);
        mem_req_t r;
        waits = 0;
        wait_neg();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && waits < 200) begin
            waits++;
            wait_neg();
        end
        if (!req_ready) begin
            check("send_accept", 0, 1);
            req_valid = 1'b0;
            return;
        end
        r.we = we;
        r.addr = addr;
        r.wdata = wd;
        exp_q.push_back(r);
        iss_q.push_back(r);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 400 && n_resp < target; i++) wait_neg();
        check("resp_count", n_resp, target);
    endtask

    task automatic do_reset();
        wait_neg();
        rst_n = 1'b0;
        exp_q.delete();
        iss_q.delete();
        wait_neg();
        wait_neg();
        rst_n = 1'b1;
    endtask

    // Memory responder: rdy_mem is raised for the edge that ends the LAT-th
    // strobe cycle of each issued request.
    always @(negedge clk) begin
        mem_req_t e;
        if (!rst_n || !mem_en) begin
            mem_cnt     = 0;
            mem_rdy_drv = 1'b0;
        end else if (we_mem || re_mem) begin
            check("strobe_onehot", we_mem & re_mem, 0);
            mem_cnt++;
            if (mem_cnt == LAT) begin
                mem_cnt     = 0;
                mem_rdy_drv = 1'b1;
                data_mem_in = rdata_fn(addr_mem);
                if (iss_q.size() == 0) begin
                    check("iss_extra", 1, 0);
                end else begin
                    e = iss_q.pop_front();
                    check("iss_we", we_mem, e.we);
                    check("iss_re", re_mem, !e.we);
                    check("iss_addr", addr_mem, e.addr);
                    if (e.we) check("iss_wdata", data_mem_out, e.wdata);
                end
            end else begin
                mem_rdy_drv = 1'b0;
                data_mem_in = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
            end
        end else begin
            mem_cnt     = 0;
            mem_rdy_drv = 1'b0;
        end
    end

    // Response monitor
    always @(negedge clk) begin
        mem_req_t e;
        if (rst_n && resp_valid) begin
            n_resp++;
            $display("resp %0d: we=%0b rdata=%h", n_resp, resp_we, resp_rdata);
            if (exp_q.size() == 0) begin
                check("resp_extra", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("resp_we", resp_we, e.we);
                check("resp_rdata", resp_rdata, e.we ? 128'h0 : rdata_fn(e.addr));
            end
        end
    end

    initial begin
        int w;
        int cnt;
        int gap;
        int base;

        // Reset state
        wait_neg();
        wait_neg();
        check("rst_ready", req_ready, 0);
        check("rst_we_mem", we_mem, 0);
        check("rst_re_mem", re_mem, 0);
        check("rst_addr_mem", addr_mem, 0);
        check("rst_data_mem_out", data_mem_out, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_we", resp_we, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_err", err_timeout, 0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", req_ready, 0);
        wait_neg();
        check("ready_after_release", req_ready, 1);

        // Single load: strobe appears one cycle after acceptance and stays
        // high for LAT cycles; exactly one response follows.
        send(1'b0, 32'h0001_0008, 128'h0, w);
        wait_neg();
        check("load_re_early", re_mem, 0);
        wait_neg();
        check("load_re_rise", re_mem, 1);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            wait_neg();
            if (!re_mem) break;
            cnt++;
        end
        check("load_re_cycles", cnt, LAT);
        check("load_resp_seen", n_resp, 1);
        wait_neg();
        check("load_resp_pulse", resp_valid, 0);
        wait_resp(1);

        // Store burst. One entry leaves for the issue register at once, so
        // the queue becomes full after the 5th push and the 6th is held until
        // the first completion pops the queue.
        base = n_resp;
        for (int i = 0; i < 5; i++)
            send(1'b1, 32'h0000_2000 + 32'(i * 4), {4{32'hA000_0000 + 32'(i)}}, w);
        check("burst_full_ready", req_ready, 0);
        send(1'b1, 32'h0000_2014, {4{32'hA000_0005}}, w);
        check("burst_sixth_waits", w, 1);
        check("burst_sixth_after_pop", n_resp, base + 1);
        gap = 0;
        for (int i = 0; i < 100 && n_resp < base + 6; i++) begin
            wait_neg();
            if (n_resp < base + 6 && !we_mem) gap++;
        end
        check("burst_we_gaps", gap, 0);
        wait_resp(base + 6);

        // 20 mixed requests. After 4 pushes the queue holds 3 entries. The
        // 5th push lands on the first completion edge (push and pop
        // together), so the 6th sees room and the 7th waits for the next
        // completion.
        base = n_resp;
        for (int i = 0; i < 4; i++)
            send(1'(i), 32'h1000_0000 + 32'(i * 16), {32'(i), 32'hCAFE_0000 + 32'(i), ~32'(i), 32'h1234_5678}, w);
        wait_neg();
        for (int i = 4; i < 20; i++) begin
            send(1'(i), 32'h1000_0000 + 32'(i * 16), {32'(i), 32'hCAFE_0000 + 32'(i), ~32'(i), 32'h1234_5678}, w);
            if (i == 4) check("wrap_fifth_waits", w, 0);
            if (i == 5) check("wrap_sixth_waits", w, 0);
            if (i == 6) check("wrap_seventh_waits", w, 3);
        end
        wait_resp(base + 20);
        check("wrap_exp_empty", exp_q.size(), 0);
        check("wrap_iss_empty", iss_q.size(), 0);

        // rdy_mem pulsed while idle is ignored
        base = n_resp;
        wait_neg();
        force_rdy = 1'b1;
        wait_neg();
        force_rdy = 1'b0;
        wait_neg();
        wait_neg();
        check("idle_rdy_no_resp", n_resp, base);
        check("idle_rdy_we", we_mem, 0);
        check("idle_rdy_re", re_mem, 0);
        check("idle_rdy_ready", req_ready, 1);
        send(1'b0, 32'h0000_3000, 128'h0, w);
        wait_resp(base + 1);

        // Reset two cycles into BUSY with two requests queued
        base = n_resp;
        for (int i = 0; i < 3; i++)
            send(1'b0, 32'h0000_4000 + 32'(i * 4), 128'h0, w);
        wait_neg();
        check("mid_busy_strobe", re_mem, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_re", re_mem, 0);
        check("mid_rst_we", we_mem, 0);
        check("mid_rst_ready", req_ready, 0);
        exp_q.delete();
        iss_q.delete();
        wait_neg();
        wait_neg();
        rst_n = 1'b1;
        wait_neg();
        check("mid_rel_ready", req_ready, 1);
        for (int i = 0; i < 10; i++) wait_neg();
        check("mid_no_resp", n_resp, base);
        check("mid_idle_re", re_mem, 0);

        // Memory never answers
        base = n_resp;
        mem_en = 1'b0;
        send(1'b0, 32'h0000_5000, 128'h0, w);
        wait_neg();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            wait_neg();
            if (re_mem) cnt++;
            if (err_timeout) break;
        end
`ifdef MEM_REQ_TIMEOUT_EN
        check("to_busy_cycles", cnt, TIMEOUT_CYCLES);
        check("to_err", err_timeout, 1);
        check("to_re_dropped", re_mem, 0);
        check("to_ready", req_ready, 0);
        wait_neg();
        wait_neg();
        check("to_err_sticky", err_timeout, 1);
`else
        check("to_busy_cycles", cnt, 40);
        check("to_err", err_timeout, 0);
        check("to_re_held", re_mem, 1);
`endif
        check("to_no_resp", n_resp, base);
        do_reset();
        mem_en = 1'b1;
        wait_neg();
        check("to_rst_err", err_timeout, 0);
        check("to_rst_ready", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
